// File: rtl/stepgen_timed.sv
// Phase-accumulator step generator: converts a signed rate command into STP/DIR pulses with
// DIR setup and STP high/low timing, a one-deep request buffer and a sticky overrun flag.
module stepgen_timed #(
   parameter int FREQ_WIDTH = 32,
   parameter int ACC_WIDTH  = 32,
   parameter int POS_WIDTH  = 32,
   parameter int PULSE_HIGH = 4,
   parameter int PULSE_LOW  = 4,
   parameter int DIR_SETUP  = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic signed [FREQ_WIDTH-1:0] jointFreqCmd,
   input  logic                         missedClr,
   output logic signed [POS_WIDTH-1:0]  jointFeedback,
   output logic                         DIR,
   output logic                         STP,
   output logic                         busy,
   output logic                         missedStep
);
   localparam int MAG_WIDTH  = FREQ_WIDTH - 1;
   localparam int WIDE_WIDTH = (ACC_WIDTH > MAG_WIDTH) ? ACC_WIDTH : MAG_WIDTH;
   localparam int MAX_T_A    = (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
   localparam int MAX_T      = (MAX_T_A > DIR_SETUP) ? MAX_T_A : DIR_SETUP;
   localparam int CNT_WIDTH  = (MAX_T > 1) ? $clog2(MAX_T) : 1;

   typedef enum logic [1:0] {
      st_idle  = 2'd0,
      st_setup = 2'd1,
      st_high  = 2'd2,
      st_low   = 2'd3
   } state_t;

   logic                   cmd_min_s;
   logic [MAG_WIDTH-1:0]   neg_s;
   logic [MAG_WIDTH-1:0]   mag_s;
   logic [WIDE_WIDTH-1:0]  mag_wide_s;
   logic [WIDE_WIDTH-1:0]  acc_max_s;
   logic [ACC_WIDTH-1:0]   mag_acc_s;
   logic [ACC_WIDTH:0]     sum_s;
   logic [ACC_WIDTH-1:0]   acc_r;
   logic                   step_req_r;
   logic                   req_sgn_r;
   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [CNT_WIDTH-1:0]   cnt_r;
   logic [CNT_WIDTH-1:0]   cnt_nxt_s;
   logic                   dir_r;
   logic                   dir_nxt_s;
   logic                   pend_r;
   logic                   pend_nxt_s;
   logic                   pend_sgn_r;
   logic                   pend_sgn_nxt_s;
   logic                   req_s;
   logic                   pend_s;
   logic                   free_s;
   logic                   take_s;
   logic                   take_sgn_s;
   logic                   miss_set_s;
   logic                   stp_r;
   logic                   busy_r;
   logic                   miss_r;
   logic [POS_WIDTH-1:0]   pos_r;

   // Command magnitude; the most-negative code and rates beyond the accumulator range saturate.
   always_comb begin
      cmd_min_s = jointFreqCmd[FREQ_WIDTH-1] && (jointFreqCmd[FREQ_WIDTH-2:0] == {MAG_WIDTH{1'b0}});
      neg_s     = ~jointFreqCmd[MAG_WIDTH-1:0] + MAG_WIDTH'(1'b1);
      if (cmd_min_s) begin
         mag_s = {MAG_WIDTH{1'b1}};
      end else if (jointFreqCmd[FREQ_WIDTH-1]) begin
         mag_s = neg_s;
      end else begin
         mag_s = jointFreqCmd[MAG_WIDTH-1:0];
      end
      mag_wide_s                 = {WIDE_WIDTH{1'b0}};
      mag_wide_s[MAG_WIDTH-1:0]  = mag_s;
      acc_max_s                  = {WIDE_WIDTH{1'b0}};
      acc_max_s[ACC_WIDTH-1:0]   = {ACC_WIDTH{1'b1}};
      if (mag_wide_s > acc_max_s) begin
         mag_acc_s = {ACC_WIDTH{1'b1}};
      end else begin
         mag_acc_s = mag_wide_s[ACC_WIDTH-1:0];
      end
      sum_s = {1'b0, acc_r} + {1'b0, mag_acc_s};
   end

   // Phase accumulator; its carry becomes a one-clock step request tagged with direction.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_r      <= {ACC_WIDTH{1'b0}};
         step_req_r <= 1'b0;
         req_sgn_r  <= 1'b0;
      end else if (enable) begin
         acc_r      <= sum_s[ACC_WIDTH-1:0];
         step_req_r <= sum_s[ACC_WIDTH];
         req_sgn_r  <= ~jointFreqCmd[FREQ_WIDTH-1];
      end else begin
         step_req_r <= 1'b0;
      end
   end

   // Request arbitration (take, buffer or drop) and pulse-sequencing next state.
   always_comb begin
      req_s          = step_req_r & enable;
      pend_s         = pend_r & enable;
      free_s         = (state_r == st_idle) ||
                       ((state_r == st_low) && (cnt_r == {CNT_WIDTH{1'b0}}));
      state_nxt_s    = state_r;
      cnt_nxt_s      = cnt_r;
      dir_nxt_s      = dir_r;
      pend_nxt_s     = pend_s;
      pend_sgn_nxt_s = pend_sgn_r;
      take_s         = 1'b0;
      take_sgn_s     = dir_r;
      miss_set_s     = 1'b0;
      // The last LOW clock behaves like IDLE, so a request landing there is never dropped.
      if (free_s) begin
         if (pend_s) begin
            take_s         = 1'b1;
            take_sgn_s     = pend_sgn_r;
            pend_nxt_s     = req_s;
            pend_sgn_nxt_s = req_sgn_r;
         end else if (req_s) begin
            take_s     = 1'b1;
            take_sgn_s = req_sgn_r;
            pend_nxt_s = 1'b0;
         end else begin
            pend_nxt_s = 1'b0;
         end
      end else if (req_s) begin
         if (pend_s) begin
            miss_set_s = 1'b1;
         end else begin
            pend_nxt_s     = 1'b1;
            pend_sgn_nxt_s = req_sgn_r;
         end
      end else begin
         pend_nxt_s = pend_s;
      end
      if (free_s) begin
         if (take_s && (take_sgn_s != dir_r)) begin
            state_nxt_s = st_setup;
            cnt_nxt_s   = CNT_WIDTH'(DIR_SETUP - 1);
            dir_nxt_s   = take_sgn_s;
         end else if (take_s) begin
            state_nxt_s = st_high;
            cnt_nxt_s   = CNT_WIDTH'(PULSE_HIGH - 1);
         end else begin
            state_nxt_s = st_idle;
            cnt_nxt_s   = {CNT_WIDTH{1'b0}};
         end
      end else begin
         case (state_r)
            st_setup: begin
               if (cnt_r == {CNT_WIDTH{1'b0}}) begin
                  state_nxt_s = st_high;
                  cnt_nxt_s   = CNT_WIDTH'(PULSE_HIGH - 1);
               end else begin
                  cnt_nxt_s = cnt_r - CNT_WIDTH'(1'b1);
               end
            end
            st_high: begin
               if (cnt_r == {CNT_WIDTH{1'b0}}) begin
                  state_nxt_s = st_low;
                  cnt_nxt_s   = CNT_WIDTH'(PULSE_LOW - 1);
               end else begin
                  cnt_nxt_s = cnt_r - CNT_WIDTH'(1'b1);
               end
            end
            st_low: begin
               cnt_nxt_s = cnt_r - CNT_WIDTH'(1'b1);
            end
            default: begin
               state_nxt_s = st_idle;
               cnt_nxt_s   = {CNT_WIDTH{1'b0}};
            end
         endcase
      end
   end

   // Sequencer state, pending buffer, position counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= st_idle;
         cnt_r      <= {CNT_WIDTH{1'b0}};
         dir_r      <= 1'b0;
         pend_r     <= 1'b0;
         pend_sgn_r <= 1'b0;
         stp_r      <= 1'b0;
         busy_r     <= 1'b0;
         miss_r     <= 1'b0;
         pos_r      <= {POS_WIDTH{1'b0}};
      end else begin
         state_r    <= state_nxt_s;
         cnt_r      <= cnt_nxt_s;
         dir_r      <= dir_nxt_s;
         pend_r     <= pend_nxt_s;
         pend_sgn_r <= pend_sgn_nxt_s;
         stp_r      <= (state_nxt_s == st_high);
         busy_r     <= (state_nxt_s != st_idle);
         miss_r     <= (miss_r & ~missedClr) | miss_set_s;
         if ((state_nxt_s == st_high) && (state_r != st_high)) begin
            pos_r <= dir_nxt_s ? (pos_r + POS_WIDTH'(1'b1)) : (pos_r - POS_WIDTH'(1'b1));
         end else begin
            pos_r <= pos_r;
         end
      end
   end

   assign jointFeedback = pos_r;
   assign DIR           = dir_r;
   assign STP           = stp_r;
   assign busy          = busy_r;
   assign missedStep    = miss_r;

endmodule

// File: tb/tb_stepgen_timed.sv
// Directed + randomized bench for stepgen_timed against an edge-scheduled reference model;
// a second instance with a 4-bit position counter exercises feedback wrap-around cheaply.
module tb_stepgen_timed;
   localparam int FW = 16, AW = 8, PW = 32, SPW = 4, PH = 2, PL = 2, DS = 3;

   logic                 clk = 1'b0;
   logic                 reset, enable, missedClr;
   logic signed [FW-1:0] cmd;
   logic signed [PW-1:0] fb;
   logic signed [SPW-1:0] fb_small;
   logic dir, stp, busy, missed;
   logic dir_small, stp_small, busy_small, missed_small;

   int checks = 0, failures = 0;
   int cyc = 0, rises, guard, dir_cyc, last_rise, base, tmp;
   logic prev_stp = 1'b0, prev_dir, rise_s = 1'b0;

   // reference model state: edge index n, scheduled rise/fall/exit edges of the current pulse
   int m_n = 0, m_acc = 0, m_rise = 0, m_fall = 0, m_exit = 0, m_pos = 0;
   bit m_req = 0, m_sgn = 0, m_pend = 0, m_psgn = 0, m_dir = 0, m_miss = 0;

   always #5 clk = ~clk;

   stepgen_timed #(.FREQ_WIDTH(FW), .ACC_WIDTH(AW), .POS_WIDTH(PW), .PULSE_HIGH(PH),
                   .PULSE_LOW(PL), .DIR_SETUP(DS)) dut (
      .clk(clk), .reset(reset), .enable(enable), .jointFreqCmd(cmd), .missedClr(missedClr),
      .jointFeedback(fb), .DIR(dir), .STP(stp), .busy(busy), .missedStep(missed));

   stepgen_timed #(.FREQ_WIDTH(FW), .ACC_WIDTH(AW), .POS_WIDTH(SPW), .PULSE_HIGH(PH),
                   .PULSE_LOW(PL), .DIR_SETUP(DS)) dut_small (
      .clk(clk), .reset(reset), .enable(enable), .jointFreqCmd(cmd), .missedClr(missedClr),
      .jointFeedback(fb_small), .DIR(dir_small), .STP(stp_small), .busy(busy_small),
      .missedStep(missed_small));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One rising edge of the reference: a free sequencer takes the buffered or new request.
   task automatic model_edge();
      int  mag, sum;
      bit  req, take, tsgn, miss_set;
      m_n++;
      if (reset) begin
         m_acc = 0; m_req = 0; m_sgn = 0; m_pend = 0; m_psgn = 0; m_dir = 0;
         m_pos = 0; m_miss = 0; m_rise = m_n; m_fall = m_n; m_exit = m_n;
         return;
      end
      req = m_req && enable;
      if (!enable) m_pend = 0;
      take = 0; tsgn = 0; miss_set = 0;
      if (m_n >= m_exit) begin
         if (m_pend) begin
            take = 1; tsgn = m_psgn; m_pend = req; m_psgn = m_sgn;
         end else if (req) begin
            take = 1; tsgn = m_sgn;
         end
      end else if (req) begin
         if (m_pend) miss_set = 1;
         else begin m_pend = 1; m_psgn = m_sgn; end
      end
      if (take) begin
         if (tsgn != m_dir) begin m_dir = tsgn; m_rise = m_n + DS; end
         else m_rise = m_n;
         m_fall = m_rise + PH;
         m_exit = m_fall + PL;
      end
      if (m_n == m_rise) m_pos = m_dir ? m_pos + 1 : m_pos - 1;
      m_miss = (m_miss && !missedClr) || miss_set;
      if (enable) begin
         mag = cmd;
         if (mag < 0) mag = -mag;
         if (mag > 32767) mag = 32767;
         if (mag > (1 << AW) - 1) mag = (1 << AW) - 1;
         sum = m_acc + mag;
         m_req = (sum >= (1 << AW));
         m_acc = sum % (1 << AW);
         m_sgn = (cmd >= 0);
      end else begin
         m_req = 0;
      end
   endtask

   task automatic tick();
      bit e_stp;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      e_stp = (m_n >= m_rise) && (m_n < m_fall);
      chk("fb", fb, m_pos);
      chk("fb_small", {28'd0, fb_small}, {28'd0, m_pos[3:0]});
      chk("dir", {31'd0, dir}, {31'd0, m_dir});
      chk("stp", {31'd0, stp}, {31'd0, e_stp});
      chk("stp_small", {31'd0, stp_small}, {31'd0, e_stp});
      chk("busy", {31'd0, busy}, {31'd0, (m_n < m_exit)});
      chk("missed", {31'd0, missed}, {31'd0, m_miss});
      cyc++;
      rise_s   = stp && !prev_stp;
      prev_stp = stp;
   endtask

   task automatic wait_idle(input string tag);
      int g = 0;
      while (busy && g < 100) begin tick(); g++; end
      chk(tag, {31'd0, busy}, 32'd0);
      tick(); tick();
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; cmd = 16'sd0; missedClr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         enable = 1'($urandom); cmd = 16'($urandom); missedClr = 1'($urandom);
         tick();
      end
      chk("rst_fb", fb, 32'd0);
      chk("rst_dir", {31'd0, dir}, 32'd0);
      chk("rst_stp", {31'd0, stp}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_missed", {31'd0, missed}, 32'd0);

      // +64: DIR rises, STP 3 clocks later, then a 4-clock period
      reset = 1'b0; enable = 1'b1; missedClr = 1'b0; cmd = 16'sd64;
      rises = 0; guard = 0; dir_cyc = -100; last_rise = -100; prev_dir = dir;
      while (rises < 10 && guard < 200) begin
         tick(); guard++;
         if (dir && !prev_dir) dir_cyc = cyc;
         prev_dir = dir;
         if (rise_s) begin
            rises++;
            if (rises == 1) chk("setup_gap_pos", cyc - dir_cyc, 32'd3);
            else chk("period_pos", cyc - last_rise, 32'd4);
            last_rise = cyc;
         end
      end
      chk("rises_pos", rises, 32'd10);
      chk("fb_pos10", fb, 32'd10);
      chk("missed_pos", {31'd0, missed}, 32'd0);
      cmd = 16'sd0;
      wait_idle("idle_after_pos");

      // -64 from idle: DIR falls, STP 3 clocks later, feedback counts down
      base = m_pos; cmd = -16'sd64;
      rises = 0; guard = 0; dir_cyc = -100; prev_dir = dir;
      while (rises < 5 && guard < 200) begin
         tick(); guard++;
         if (!dir && prev_dir) dir_cyc = cyc;
         prev_dir = dir;
         if (rise_s) begin
            rises++;
            if (rises == 1) chk("setup_gap_neg", cyc - dir_cyc, 32'd3);
            else chk("period_neg", cyc - last_rise, 32'd4);
            last_rise = cyc;
         end
      end
      chk("fb_neg5", fb, base - 5);
      cmd = 16'sd0;
      wait_idle("idle_after_neg");

      // +255: back-to-back pulses at the minimum 4-clock period, overrun flagged
      cmd = 16'sd255; rises = 0;
      for (int i = 0; i < 120; i++) begin
         if (i == 60) missedClr = 1'b1; else missedClr = 1'b0;
         tick();
         if (rise_s) begin
            rises++;
            if (rises > 1) chk("period_max", cyc - last_rise, 32'd4);
            last_rise = cyc;
         end
      end
      chk("missed_set", {31'd0, missed}, 32'd1);
      cmd = 16'sd32;
      for (int i = 0; i < 12; i++) tick();
      missedClr = 1'b1; tick(); missedClr = 1'b0;
      for (int i = 0; i < 80; i++) begin
         tick();
         chk("missed_cleared", {31'd0, missed}, 32'd0);
      end

      // most-negative command saturates; full-scale commands in both directions
      cmd = -16'sd32768;
      for (int i = 0; i < 60; i++) tick();
      chk("no_x_fb", {31'd0, $isunknown(fb)}, 32'd0);
      cmd = 16'sd32767;
      for (int i = 0; i < 20; i++) tick();

      // zero command, then disabled: no pulses, feedback frozen
      cmd = 16'sd0;
      wait_idle("idle_before_zero");
      base = m_pos; rises = 0;
      for (int i = 0; i < 40; i++) begin tick(); if (rise_s) rises++; end
      chk("rises_zero_cmd", rises, 32'd0);
      chk("fb_zero_cmd", fb, base);
      enable = 1'b0; cmd = 16'sd100; rises = 0;
      for (int i = 0; i < 40; i++) begin tick(); if (rise_s) rises++; end
      chk("rises_disabled", rises, 32'd0);
      chk("fb_disabled", fb, base);

      // randomized operation against the model
      for (int blk = 0; blk < 200; blk++) begin
         enable = ($urandom % 8) != 0;
         case ($urandom % 6)
            0: cmd = 16'($urandom);
            1, 2: begin
               tmp = $urandom_range(0, 80);
               if ($urandom % 2 == 1) tmp = -tmp;
               cmd = 16'(tmp);
            end
            3: cmd = 16'sd0;
            4: cmd = -16'sd32768;
            default: cmd = ($urandom % 2 == 1) ? 16'sd255 : -16'sd255;
         endcase
         for (int i = 0; i < 8; i++) begin
            missedClr = ($urandom % 16) == 0;
            reset     = ($urandom % 300) == 0;
            tick();
         end
      end

      // reset while STP is high
      reset = 1'b1; missedClr = 1'b0; tick(); tick();
      reset = 1'b0; enable = 1'b1; cmd = 16'sd64; guard = 0;
      while (!stp && guard < 100) begin tick(); guard++; end
      chk("reached_high", {31'd0, stp}, 32'd1);
      reset = 1'b1; tick();
      chk("rst_mid_stp", {31'd0, stp}, 32'd0);
      chk("rst_mid_fb", fb, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);

      // position wrap on the narrow instance: 7 -> -8
      tick();
      reset = 1'b0; rises = 0; guard = 0;
      while (rises < 8 && guard < 300) begin
         tick(); guard++;
         if (rise_s) begin
            rises++;
            if (rises == 7) chk("small_at_max", {28'd0, fb_small}, 32'h7);
         end
      end
      chk("small_wrapped", {28'd0, fb_small}, 32'h8);
      chk("wide_no_wrap", fb, 32'd8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
